// File: rtl/config_loader_pkg.sv
// Shared constants, FSM state encoding and sizing helper for the pulser configuration loader.
package config_loader_pkg;

    localparam logic [2:0] HANDSHAKE_DEF = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MASK  = 3'd1,
        S_COUNT = 3'd2,
        S_DATA  = 3'd3,
        S_CSUM  = 3'd4
    } state_e;

    // Bits needed to index v items; never returns 0 so single-item counters still have a bit.
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/config_loader_delay_bank.sv
// Per-channel delay storage: NUM_ALINES words, synchronous write, registered read.
// Reads see the pre-write contents when the same row is written in the same cycle.
module config_loader_delay_bank #(
    parameter int NUM_ALINES = 16,
    parameter int DELAY_W    = 16,
    parameter int AW         = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en_i,
    input  logic [AW-1:0]      wr_row_i,
    input  logic [DELAY_W-1:0] wr_data_i,
    input  logic [AW-1:0]      rd_row_i,
    output logic [DELAY_W-1:0] rd_data_o
);

    localparam logic [AW:0] ROWS = (AW+1)'(NUM_ALINES);

    logic [DELAY_W-1:0] mem_q [NUM_ALINES];
    logic [DELAY_W-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ALINES; i++) begin
                mem_q[i] <= '0;
            end
            rd_q <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_row_i] <= wr_data_i;
            end
            if ({1'b0, rd_row_i} < ROWS) begin
                rd_q <= mem_q[rd_row_i];
            end else begin
                rd_q <= '0;
            end
        end
    end

    assign rd_data_o = rd_q;

endmodule

// File: rtl/config_loader.sv
// UART frame parser: handshake, channel mask, A-line count, delay words, XOR checksum.
// Loads per-channel delay banks and serves one A-line row of delays to the sequencer.
module config_loader
    import config_loader_pkg::*;
#(
    parameter int         NUM_CH      = 8,
    parameter int         NUM_ALINES  = 16,
    parameter int         DELAY_W     = 16,
    parameter logic [2:0] HANDSHAKE   = HANDSHAKE_DEF,
    parameter int         TIMEOUT_CYC = 100000,
    localparam int        AW          = clog2_min1(NUM_ALINES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    input  logic [AW-1:0]             aline_sel,
    output logic [NUM_CH*DELAY_W-1:0] ch_delay,
    output logic [NUM_CH-1:0]         channel_select,
    output logic [AW:0]               aline_count,
    output logic                      busy,
    output logic                      cfg_done,
    output logic                      cfg_err,
    output logic [2:0]                dbg_state_o
);

    localparam int MB  = (NUM_CH + 7) / 8;
    localparam int WB  = DELAY_W / 8;
    localparam int CW  = clog2_min1(NUM_CH);
    localparam int BW  = clog2_min1(WB);
    localparam int MBW = clog2_min1(MB);
    localparam int TW  = clog2_min1(TIMEOUT_CYC + 1);

    state_e             state_q;
    logic [MB*8-1:0]    mask_q;
    logic [NUM_CH-1:0]  sel_q;
    logic [AW:0]        cnt_q;
    logic [AW:0]        n_q;
    logic [AW-1:0]      a_q;
    logic [CW-1:0]      ch_q;
    logic [BW-1:0]      byte_q;
    logic [MBW-1:0]     mbyte_q;
    logic [DELAY_W-1:0] word_q;
    logic [7:0]         csum_q;
    logic [TW-1:0]      timer_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    logic [7:0]         csum_d;
    logic [DELAY_W-1:0] word_d;
    logic [MB*8-1:0]    mask_d;
    logic               word_last;
    logic               ch_last;
    logic               row_last;
    logic               mask_last;
    logic               count_bad;
    logic               timeout_hit;
    logic               wr_fire;
    logic [NUM_CH-1:0]  wr_en;

    // Bytes arrive MSB first, so each new byte shifts in at the bottom.
    always_comb begin
        csum_d      = csum_q ^ rx_data;
        word_d      = DELAY_W'({word_q, rx_data});
        mask_d      = (MB*8)'({mask_q, rx_data});
        word_last   = (byte_q == BW'(WB - 1));
        ch_last     = (ch_q == CW'(NUM_CH - 1));
        row_last    = ({1'b0, a_q} == (n_q - 1'b1));
        mask_last   = (mbyte_q == MBW'(MB - 1));
        count_bad   = (rx_data == 8'd0) || (int'(rx_data) > NUM_ALINES);
        timeout_hit = (timer_q == TW'(TIMEOUT_CYC - 1));
        wr_fire     = (state_q == S_DATA) && rx_valid && word_last;
    end

    // Unmasked channels still consume their word; only the write is suppressed.
    always_comb begin
        wr_en = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            wr_en[c] = wr_fire && (ch_q == CW'(c)) && mask_q[c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            n_q     <= '0;
            a_q     <= '0;
            ch_q    <= '0;
            byte_q  <= '0;
            mbyte_q <= '0;
            word_q  <= '0;
            csum_q  <= '0;
            timer_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            timer_q <= (busy_q && !rx_valid) ? timer_q + 1'b1 : '0;
            if (state_q == S_IDLE) begin
                if (rx_valid && (rx_data[7:5] == HANDSHAKE)) begin
                    state_q <= S_MASK;
                    busy_q  <= 1'b1;
                    csum_q  <= '0;
                    mbyte_q <= '0;
                end
            end else if (rx_valid) begin
                csum_q <= csum_d;
                case (state_q)
                    S_MASK: begin
                        mask_q  <= mask_d;
                        mbyte_q <= mbyte_q + 1'b1;
                        if (mask_last) begin
                            state_q <= S_COUNT;
                        end
                    end
                    S_COUNT: begin
                        if (count_bad) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            n_q     <= (AW+1)'(rx_data);
                            a_q     <= '0;
                            ch_q    <= '0;
                            byte_q  <= '0;
                            state_q <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        word_q <= word_d;
                        if (!word_last) begin
                            byte_q <= byte_q + 1'b1;
                        end else begin
                            byte_q <= '0;
                            if (!ch_last) begin
                                ch_q <= ch_q + 1'b1;
                            end else begin
                                ch_q <= '0;
                                if (row_last) begin
                                    state_q <= S_CSUM;
                                end else begin
                                    a_q <= a_q + 1'b1;
                                end
                            end
                        end
                    end
                    S_CSUM: begin
                        // Including the checksum byte itself, a good frame XORs to zero.
                        if (rx_data == csum_q) begin
                            done_q <= 1'b1;
                            sel_q  <= mask_q[NUM_CH-1:0];
                            cnt_q  <= n_q;
                        end else begin
                            err_q <= 1'b1;
                        end
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end else if (timeout_hit) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                err_q   <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_bank
        config_loader_delay_bank #(
            .NUM_ALINES (NUM_ALINES),
            .DELAY_W    (DELAY_W),
            .AW         (AW)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .wr_en_i   (wr_en[g]),
            .wr_row_i  (a_q),
            .wr_data_i (word_d),
            .rd_row_i  (aline_sel),
            .rd_data_o (ch_delay[g*DELAY_W +: DELAY_W])
        );
    end

    assign channel_select = sel_q;
    assign aline_count    = cnt_q;
    assign busy           = busy_q;
    assign cfg_done       = done_q;
    assign cfg_err        = err_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: default-size instance A and a 12ch/24b/4-row instance B.
module tb_config_loader;

  localparam int TO = 200;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]   a_rx_data, b_rx_data;
  logic         a_rx_valid, b_rx_valid;
  logic [3:0]   a_sel;
  logic [1:0]   b_sel;
  logic [127:0] a_dly;
  logic [287:0] b_dly;
  logic [7:0]   a_cs;
  logic [11:0]  b_cs;
  logic [4:0]   a_cnt;
  logic [2:0]   b_cnt;
  logic         a_busy, a_done, a_err, b_busy, b_done, b_err;
  logic [2:0]   a_dbg, b_dbg;

  config_loader #(.NUM_CH(8), .NUM_ALINES(16), .DELAY_W(16), .TIMEOUT_CYC(TO)) dut_a (
    .clk(clk), .rst(rst), .rx_data(a_rx_data), .rx_valid(a_rx_valid), .aline_sel(a_sel),
    .ch_delay(a_dly), .channel_select(a_cs), .aline_count(a_cnt), .busy(a_busy),
    .cfg_done(a_done), .cfg_err(a_err), .dbg_state_o(a_dbg));

  config_loader #(.NUM_CH(12), .NUM_ALINES(4), .DELAY_W(24), .TIMEOUT_CYC(TO)) dut_b (
    .clk(clk), .rst(rst), .rx_data(b_rx_data), .rx_valid(b_rx_valid), .aline_sel(b_sel),
    .ch_delay(b_dly), .channel_select(b_cs), .aline_count(b_cnt), .busy(b_busy),
    .cfg_done(b_done), .cfg_err(b_err), .dbg_state_o(b_dbg));

  int checks;
  int failures;

  logic [15:0]  mdl_a [8][16];
  logic [23:0]  mdl_b [12][4];
  logic [7:0]   exp_sel_a;
  logic [4:0]   exp_cnt_a;
  logic [11:0]  exp_sel_b;
  logic [2:0]   exp_cnt_b;
  logic [511:0] exp_q[$];
  logic [7:0]   frame_q[$];
  logic [31:0]  words_q[$];

  typedef struct {
    bit          pre_rst;
    logic [7:0]  mask;
    int          n;
    bit          bad;
    bit          exp_done;
    bit          exp_err;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_models();
    for (int c = 0; c < 8; c++) for (int r = 0; r < 16; r++) mdl_a[c][r] = '0;
    for (int c = 0; c < 12; c++) for (int r = 0; r < 4; r++) mdl_b[c][r] = '0;
    exp_sel_a = '0; exp_cnt_a = '0; exp_sel_b = '0; exp_cnt_b = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_models();
  endtask

  // Frame = handshake, mask bytes (MSB first), count, words (MSB first), XOR checksum.
  task automatic build_frame(input int mb, input int wb, input logic [15:0] mask,
                             input int n, input bit bad, input bit count_only);
    logic [7:0] cs;
    frame_q.delete();
    frame_q.push_back({3'b110, 5'($urandom_range(0, 31))});
    for (int m = mb - 1; m >= 0; m--) frame_q.push_back(mask[8*m +: 8]);
    frame_q.push_back(8'(n));
    if (!count_only) begin
      foreach (words_q[i]) for (int b = wb - 1; b >= 0; b--) frame_q.push_back(words_q[i][8*b +: 8]);
      cs = '0;
      for (int i = 1; i < frame_q.size(); i++) cs = cs ^ frame_q[i];
      if (bad) cs = cs ^ 8'(1 << $urandom_range(0, 7));
      frame_q.push_back(cs);
    end
  endtask

  task automatic send_a(input logic [7:0] b);
    a_rx_data = b;
    a_rx_valid = 1'b1;
    @(negedge clk);
    a_rx_valid = 1'b0;
    a_rx_data = 8'($urandom);
  endtask

  task automatic send_b(input logic [7:0] b);
    b_rx_data = b;
    b_rx_valid = 1'b1;
    @(negedge clk);
    b_rx_valid = 1'b0;
    b_rx_data = 8'($urandom);
  endtask

  task automatic send_frame_a(input int gap_max);
    int early;
    early = 0;
    for (int i = 0; i < frame_q.size(); i++) begin
      send_a(frame_q[i]);
      if (i != frame_q.size() - 1) begin
        if (a_done || a_err) early++;
        repeat ($urandom_range(0, gap_max)) begin
          @(negedge clk);
          if (a_done || a_err) early++;
        end
      end
    end
    check("a_no_early_pulse", early, 0);
  endtask

  task automatic send_frame_b(input int gap_max);
    int early;
    early = 0;
    for (int i = 0; i < frame_q.size(); i++) begin
      send_b(frame_q[i]);
      if (i != frame_q.size() - 1) begin
        if (b_done || b_err) early++;
        repeat ($urandom_range(0, gap_max)) begin
          @(negedge clk);
          if (b_done || b_err) early++;
        end
      end
    end
    check("b_no_early_pulse", early, 0);
  endtask

  task automatic model_write_a(input logic [7:0] mask, input int n);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < 8; c++)
        if (mask[c]) mdl_a[c][r] = words_q[r*8 + c][15:0];
  endtask

  task automatic model_write_b(input logic [11:0] mask, input int n);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < 12; c++)
        if (mask[c]) mdl_b[c][r] = words_q[r*12 + c][23:0];
  endtask

  task automatic check_rows_a(input string tag);
    logic [511:0] e;
    for (int r = 0; r < 16; r++) begin
      e = '0;
      for (int c = 0; c < 8; c++) e[c*16 +: 16] = mdl_a[c][r];
      exp_q.push_back(e);
      a_sel = 4'(r);
      @(negedge clk);
      check(tag, a_dly, exp_q.pop_front());
    end
  endtask

  task automatic check_rows_b(input string tag);
    logic [511:0] e;
    for (int r = 0; r < 4; r++) begin
      e = '0;
      for (int c = 0; c < 12; c++) e[c*24 +: 24] = mdl_b[c][r];
      exp_q.push_back(e);
      b_sel = 2'(r);
      @(negedge clk);
      check(tag, b_dly, exp_q.pop_front());
    end
  endtask

  task automatic fill_pattern_a(input int n);
    words_q.delete();
    for (int r = 0; r < n; r++) for (int c = 0; c < 8; c++) words_q.push_back(32'(16'h0100 * (r + 1) + c));
  endtask

  task automatic fill_random_a(input int n);
    words_q.delete();
    for (int i = 0; i < n * 8; i++) words_q.push_back(32'($urandom_range(0, 65535)));
  endtask

  task automatic fill_random_b(input int n);
    words_q.delete();
    for (int i = 0; i < n * 12; i++) words_q.push_back(32'($urandom) & 32'h00ff_ffff);
  endtask

  // Runs one frame on A and checks pulses, commit registers and every storage row.
  task automatic run_frame_a(input logic [7:0] mask, input int n, input bit bad,
                             input bit exp_done, input bit exp_err, input string tag);
    bit cnt_err;
    cnt_err = (n == 0) || (n > 16);
    build_frame(1, 2, 16'(mask), n, bad, cnt_err);
    send_frame_a($urandom_range(0, 3));
    check({tag, "_done"}, a_done, exp_done);
    check({tag, "_err"}, a_err, exp_err);
    check({tag, "_busy"}, a_busy, 1'b0);
    if (!cnt_err) model_write_a(mask, n);
    if (exp_done) begin
      exp_sel_a = mask;
      exp_cnt_a = 5'(n);
    end
    @(negedge clk);
    check({tag, "_pulse_len"}, {a_done, a_err}, 2'b00);
    check({tag, "_sel"}, a_cs, exp_sel_a);
    check({tag, "_cnt"}, a_cnt, exp_cnt_a);
    check_rows_a({tag, "_rows"});
  endtask

  initial begin
    int k;
    logic [15:0] old_v, new_v;
    logic [7:0] rmask;
    int rn;
    bit rbad;
    logic [11:0] bmask;

    checks = 0;
    failures = 0;
    rst = 1'b1;
    a_rx_data = '0; a_rx_valid = 1'b0; a_sel = '0;
    b_rx_data = '0; b_rx_valid = 1'b0; b_sel = '0;

    vecs[0] = '{0, 8'hFF, 2,  0, 1, 0};
    vecs[1] = '{1, 8'h05, 2,  0, 1, 0};
    vecs[2] = '{0, 8'hFF, 3,  1, 0, 1};
    vecs[3] = '{0, 8'hFF, 0,  0, 0, 1};
    vecs[4] = '{0, 8'hFF, 17, 0, 0, 1};
    vecs[5] = '{0, 8'h0A, 16, 0, 1, 0};
    vecs[6] = '{0, 8'h00, 1,  0, 1, 0};
    vecs[7] = '{0, 8'h81, 1,  1, 0, 1};

    do_reset();
    @(negedge clk);
    check("rst_a_outputs", {a_dly, a_cs, a_cnt, a_busy, a_done, a_err}, '0);
    check("rst_b_outputs", {b_dly, b_cs, b_cnt, b_busy, b_done, b_err}, '0);
    check("rst_a_state", a_dbg, 3'd0);

    // Non-handshake bytes in idle must be ignored.
    send_a(8'h5A);
    send_a(8'hE0);
    send_a(8'h20);
    check("idle_ignore_busy", a_busy, 1'b0);

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].pre_rst) do_reset();
      fill_pattern_a(vecs[v].n);
      run_frame_a(vecs[v].mask, vecs[v].n, vecs[v].bad, vecs[v].exp_done, vecs[v].exp_err,
                  $sformatf("vec%0d", v));
      if (v == 0) begin
        a_sel = 4'd1;
        @(negedge clk);
        check("vec0_row1_ch3", a_dly[63:48], 16'h0203);
      end
    end

    // Frame stalls after 5 data bytes; timeout must fire exactly TO idle cycles later.
    fill_pattern_a(2);
    words_q[0] = 32'h0000_3131;
    words_q[1] = 32'h0000_4242;
    build_frame(1, 2, 16'hFF, 2, 0, 0);
    for (int i = 0; i < 8; i++) send_a(frame_q[i]);
    check("to_busy_mid", a_busy, 1'b1);
    k = 0;
    for (int j = 1; j <= TO + 10; j++) begin
      @(negedge clk);
      if (a_err || a_done) begin
        k = j;
        break;
      end
    end
    check("to_cycles", k, TO);
    check("to_err", {a_err, a_done}, 2'b10);
    check("to_busy", a_busy, 1'b0);
    mdl_a[0][0] = 16'h3131;
    mdl_a[1][0] = 16'h4242;
    fill_random_a(3);
    run_frame_a(8'hFF, 3, 0, 1, 0, "after_to");

    // Reset in the middle of the data phase.
    fill_random_a(4);
    build_frame(1, 2, 16'hFF, 4, 0, 0);
    for (int i = 0; i < 12; i++) send_a(frame_q[i]);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_pulse", {a_done, a_err}, 2'b00);
    rst = 1'b0;
    clear_models();
    repeat (3) begin
      @(negedge clk);
      check("midrst_quiet", {a_done, a_err, a_busy}, 3'b000);
    end
    check("midrst_sel_cnt", {a_cs, a_cnt}, '0);
    check_rows_a("midrst_rows");

    // Same-cycle write and read of cell (row 1, ch 3).
    fill_random_a(2);
    old_v = words_q[11][15:0];
    run_frame_a(8'hFF, 2, 0, 1, 0, "rw_setup");
    fill_random_a(2);
    words_q[11] = 32'(old_v ^ 16'h5AA5);
    new_v = words_q[11][15:0];
    build_frame(1, 2, 16'hFF, 2, 0, 0);
    a_sel = 4'd1;
    @(negedge clk);
    for (int i = 0; i < frame_q.size(); i++) begin
      send_a(frame_q[i]);
      if (i == 26) begin
        check("rw_old", a_dly[63:48], old_v);
        @(negedge clk);
        check("rw_new", a_dly[63:48], new_v);
      end
    end
    check("rw_done", a_done, 1'b1);
    model_write_a(8'hFF, 2);
    check_rows_a("rw_rows");

    // Randomised frames on A.
    for (int it = 0; it < 6; it++) begin
      rmask = 8'($urandom);
      rn = $urandom_range(1, 16);
      rbad = ($urandom_range(0, 3) == 0);
      fill_random_a(rn);
      if (it == 0) words_q[0] = 32'h0000_C0C1;
      run_frame_a(rmask, rn, rbad, !rbad, rbad, $sformatf("rnd%0d", it));
    end

    // Instance B: two mask bytes, 3-byte words, 4 rows.
    for (int it = 0; it < 5; it++) begin
      bmask = 12'($urandom);
      rn = $urandom_range(1, 4);
      rbad = (it == 2);
      fill_random_b(rn);
      build_frame(2, 3, 16'(bmask), rn, rbad, 0);
      send_frame_b($urandom_range(0, 3));
      check("b_done", b_done, !rbad);
      check("b_err", b_err, rbad);
      model_write_b(bmask, rn);
      if (!rbad) begin
        exp_sel_b = bmask;
        exp_cnt_b = 3'(rn);
      end
      @(negedge clk);
      check("b_sel", b_cs, exp_sel_b);
      check("b_cnt", b_cnt, exp_cnt_b);
      check_rows_b($sformatf("b_rows%0d", it));
    end
    build_frame(2, 3, 16'hFFF, 5, 0, 1);
    send_frame_b(2);
    check("b_count5_err", {b_err, b_done, b_busy}, 3'b100);
    @(negedge clk);
    check("b_count5_sel", b_cs, exp_sel_b);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
